// File: rtl/blit_sramctl_if.sv
// Port bundle for blit_sramctl: the arbiter-side ram_* handshake plus the
// external asynchronous SRAM pins. Master = requester/SRAM model, slave = controller.
interface blit_sramctl_if;
  logic        ram_req;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_wstrb;
  logic        ram_we;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        busy;

  modport master (
    output ram_req, ram_addr, ram_wdata, ram_wstrb, ram_we, sram_dq_i,
    input  ram_ack, ram_rdata, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy
  );

  modport slave (
    input  ram_req, ram_addr, ram_wdata, ram_wstrb, ram_we, sram_dq_i,
    output ram_ack, ram_rdata, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy
  );
endinterface

// File: rtl/blit_sramctl.sv
// Single-word sequencer for the 256Kx16 async SRAM with programmable wait states
// and read->write turnaround. Define BLIT_SRAM_WSTRB_EN for per-byte write strobes.
module blit_sramctl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic           clk,
  input  logic           rstn,
  blit_sramctl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_TURN} state_t;

  localparam logic [3:0] RD_CNT   = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT   = 4'(WR_WAIT - 1);
  localparam logic [3:0] TURN_CNT = 4'(TURN - 1);

  state_t     state, nstate;
  logic [3:0] cnt, ncnt;
  logic       pend, npend;
  logic       we_q;
  logic       accept;
  logic       n_ack, n_cap;
  logic       n_ce, n_oe, n_we, n_ub, n_lb, n_dqoe;
  logic [1:0] bstrb;

  // A second request while one is already parked in TURN is a protocol error.
  assign accept   = bus.ram_req && (state == S_IDLE || (state == S_TURN && !pend));
  assign bus.busy = (state != S_IDLE);

`ifdef BLIT_SRAM_WSTRB_EN
  logic [1:0] wstrb_q;
  assign bstrb = wstrb_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)                     wstrb_q <= 2'b00;
    else if (accept && bus.ram_we) wstrb_q <= bus.ram_wstrb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.ram_wstrb;
  assign bstrb        = 2'b11;
`endif

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    npend  = pend;
    n_ack  = 1'b0;
    n_cap  = 1'b0;
    case (state)
      S_IDLE:
        if (accept) begin
          nstate = bus.ram_we ? S_WSETUP : S_RD;
          ncnt   = RD_CNT;
        end
      S_RD:
        if (cnt == 4'd0) begin
          n_cap = 1'b1;
          n_ack = 1'b1;
          if (TURN == 0) nstate = S_IDLE;
          else begin
            nstate = S_TURN;
            ncnt   = TURN_CNT;
          end
        end else ncnt = cnt - 4'd1;
      S_WSETUP: begin
        nstate = S_WPULSE;
        ncnt   = WR_CNT;
      end
      S_WPULSE:
        if (cnt == 4'd0) begin
          nstate = S_WHOLD;
          n_ack  = 1'b1;
        end else ncnt = cnt - 4'd1;
      S_WHOLD: nstate = S_IDLE;
      S_TURN:
        // Reads may follow a read at once; writes must wait out the gap.
        if (pend && !we_q) begin
          nstate = S_RD;
          ncnt   = RD_CNT;
          npend  = 1'b0;
        end else if (cnt == 4'd0) begin
          if (pend) begin
            nstate = S_WSETUP;
            npend  = 1'b0;
          end else if (accept) begin
            nstate = bus.ram_we ? S_WSETUP : S_RD;
            ncnt   = RD_CNT;
          end else nstate = S_IDLE;
        end else begin
          ncnt = cnt - 4'd1;
          if (accept) npend = 1'b1;
        end
      default: nstate = S_IDLE;
    endcase

    // Pin values are decoded from the next state so they register with it.
    n_ce   = 1'b1;
    n_oe   = 1'b1;
    n_we   = 1'b1;
    n_ub   = 1'b1;
    n_lb   = 1'b1;
    n_dqoe = 1'b0;
    case (nstate)
      S_RD: begin
        n_ce = 1'b0; n_oe = 1'b0; n_ub = 1'b0; n_lb = 1'b0;
      end
      S_WSETUP: begin
        n_ce = 1'b0; n_dqoe = 1'b1;
      end
      S_WPULSE: begin
        n_ce = 1'b0; n_we = 1'b0; n_dqoe = 1'b1;
        n_ub = ~bstrb[1]; n_lb = ~bstrb[0];
      end
      S_WHOLD: n_dqoe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      pend           <= 1'b0;
      we_q           <= 1'b0;
      bus.sram_a     <= 18'd0;
      bus.sram_dq_o  <= 16'd0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_ub_n  <= 1'b1;
      bus.sram_lb_n  <= 1'b1;
      bus.ram_ack    <= 1'b0;
      bus.ram_rdata  <= 16'd0;
    end else begin
      state          <= nstate;
      cnt            <= ncnt;
      pend           <= npend;
      bus.sram_dq_oe <= n_dqoe;
      bus.sram_ce_n  <= n_ce;
      bus.sram_oe_n  <= n_oe;
      bus.sram_we_n  <= n_we;
      bus.sram_ub_n  <= n_ub;
      bus.sram_lb_n  <= n_lb;
      bus.ram_ack    <= n_ack;
      if (accept) begin
        we_q       <= bus.ram_we;
        bus.sram_a <= bus.ram_addr;
        if (bus.ram_we) bus.sram_dq_o <= bus.ram_wdata;
      end
      if (n_cap) bus.ram_rdata <= bus.sram_dq_i;
    end
  end

endmodule

// File: tb/tb_blit_sramctl.sv
// Directed bench for blit_sramctl: latency, strobe shapes, turnaround, ignored
// requests and mid-cycle reset, with a free-running pin monitor.
module tb_blit_sramctl;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int TURN    = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  blit_sramctl_if bus();

  blit_sramctl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Pin monitor: cumulative counters sampled mid-cycle, only out of reset.
  int ack_cnt = 0, oe_lo = 0, we_lo = 0, ub_lo = 0, lb_lo = 0, dqoe_hi = 0;
  int conflict = 0, turn_bad = 0, a_bad = 0, dq_bad = 0;
  int since_oe = 15;
  logic        prev_strobe = 1'b0, prev_dqoe = 1'b0;
  logic [17:0] prev_a = '0;
  logic [15:0] prev_dq = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      since_oe    = 15;
      prev_strobe = 1'b0;
      prev_dqoe   = 1'b0;
    end else begin
      logic strobe;
      strobe = !bus.sram_ce_n || !bus.sram_oe_n || !bus.sram_we_n;
      if (bus.ram_ack) ack_cnt++;
      if (!bus.sram_oe_n) oe_lo++;
      if (!bus.sram_we_n) begin
        we_lo++;
        if (!bus.sram_ub_n) ub_lo++;
        if (!bus.sram_lb_n) lb_lo++;
      end
      if (bus.sram_dq_oe) dqoe_hi++;
      if (bus.sram_dq_oe && !bus.sram_oe_n) conflict++;
      if (!bus.sram_oe_n) since_oe = 0;
      else if (since_oe < 15) since_oe++;
      if (bus.sram_dq_oe && since_oe <= TURN) turn_bad++;
      if (strobe && prev_strobe && bus.sram_a !== prev_a) a_bad++;
      if (bus.sram_dq_oe && prev_dqoe && bus.sram_dq_o !== prev_dq) dq_bad++;
      prev_strobe = strobe;
      prev_dqoe   = bus.sram_dq_oe;
      prev_a      = bus.sram_a;
      prev_dq     = bus.sram_dq_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] s);
    bus.ram_we    = we;
    bus.ram_addr  = a;
    bus.ram_wdata = d;
    bus.ram_wstrb = s;
    bus.ram_req   = 1'b1;
    tick();
    bus.ram_req   = 1'b0;
  endtask

  // Latency counted from the request edge; the issue tick is cycle 1.
  task automatic wait_ack(output int lat);
    lat = 1;
    while (bus.ram_ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, s_ack, s_oe, s_we, s_ub, s_lb, s_dq, s_tb, s_cf;
    bus.ram_req   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wstrb = '0;
    bus.sram_dq_i = '0;

    // Reset state
    #12;
    chk("rst_ack",     {31'd0, bus.ram_ack},    32'd0);
    chk("rst_rdata",   {16'd0, bus.ram_rdata},  32'd0);
    chk("rst_busy",    {31'd0, bus.busy},       32'd0);
    chk("rst_a",       {14'd0, bus.sram_a},     32'd0);
    chk("rst_dq_o",    {16'd0, bus.sram_dq_o},  32'd0);
    chk("rst_dq_oe",   {31'd0, bus.sram_dq_oe}, 32'd0);
    chk("rst_strobes", {27'd0, strobes()},      32'h1F);
    tick();
    rstn = 1'b1;
    tick();

    // Basic read
    bus.sram_dq_i = 16'hBEEF;
    s_oe = oe_lo;
    issue(1'b0, 18'h00123, 16'h0000, 2'b11);
    chk("rd_busy", {31'd0, bus.busy}, 32'd1);
    wait_ack(lat);
    chk("rd_lat",   lat, 32'd3);
    chk("rd_rdata", {16'd0, bus.ram_rdata}, 32'hBEEF);
    chk("rd_a",     {14'd0, bus.sram_a}, 32'h00123);
    wait_idle();
    chk("rd_oe_lo", oe_lo - s_oe, 32'd2);

    // Write at top address, upper byte only
    s_we = we_lo; s_ub = ub_lo; s_lb = lb_lo; s_dq = dqoe_hi;
    issue(1'b1, 18'h3FFFF, 16'h1234, 2'b10);
    chk("wr_setup_oe", {31'd0, bus.sram_dq_oe}, 32'd1);
    wait_ack(lat);
    chk("wr_lat",  lat, 32'd4);
    chk("wr_a",    {14'd0, bus.sram_a}, 32'h3FFFF);
    chk("wr_dq_o", {16'd0, bus.sram_dq_o}, 32'h1234);
    wait_idle();
    chk("wr_we_lo",  we_lo - s_we, 32'd2);
    chk("wr_ub_lo",  ub_lo - s_ub, 32'd2);
`ifdef BLIT_SRAM_WSTRB_EN
    chk("wr_lb_lo",  lb_lo - s_lb, 32'd0);
`else
    chk("wr_lb_lo",  lb_lo - s_lb, 32'd2);
`endif
    chk("wr_dqoe_hi", dqoe_hi - s_dq, 32'd4);
    chk("wr_idle_oe", {31'd0, bus.sram_dq_oe}, 32'd0);

    // Read then a write issued during the ack cycle: accepted in TURN
    s_ack = ack_cnt; s_tb = turn_bad;
    bus.sram_dq_i = 16'h0F0F;
    issue(1'b0, 18'h00040, 16'h0000, 2'b11);
    wait_ack(lat);
    chk("rw_rd_lat", lat, 32'd3);
    issue(1'b1, 18'h00041, 16'h5A5A, 2'b11);
    chk("rw_busy",  {31'd0, bus.busy},       32'd1);
    chk("rw_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd1);
    chk("rw_oe_n",  {31'd0, bus.sram_oe_n},  32'd1);
    wait_ack(lat);
    chk("rw_wr_lat", lat, 32'd4);
    wait_idle();
    chk("rw_acks",     ack_cnt - s_ack,   32'd2);
    chk("rw_turn_gap", turn_bad - s_tb,   32'd0);
    chk("rw_rdata",    {16'd0, bus.ram_rdata}, 32'h0F0F);

    // Request during WPULSE must be ignored
    s_ack = ack_cnt; s_oe = oe_lo;
    issue(1'b1, 18'h00077, 16'hC3C3, 2'b11);
    tick();
    chk("viol_we_n", {31'd0, bus.sram_we_n}, 32'd0);
    issue(1'b0, 18'h00099, 16'h0000, 2'b11);
    wait_idle();
    repeat (6) tick();
    chk("viol_acks", ack_cnt - s_ack, 32'd1);
    chk("viol_oe",   oe_lo - s_oe,    32'd0);
    chk("viol_busy", {31'd0, bus.busy}, 32'd0);
    chk("viol_a",    {14'd0, bus.sram_a}, 32'h00077);

    // Reset during the first RD cycle
    issue(1'b0, 18'h00200, 16'h0000, 2'b11);
    chk("mid_oe_lo", {31'd0, bus.sram_oe_n}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_strobes", {27'd0, strobes()},      32'h1F);
    chk("mid_dq_oe",   {31'd0, bus.sram_dq_oe}, 32'd0);
    chk("mid_busy",    {31'd0, bus.busy},       32'd0);
    chk("mid_rdata",   {16'd0, bus.ram_rdata},  32'd0);
    tick();
    tick();
    rstn = 1'b1;
    s_ack = ack_cnt;
    repeat (5) tick();
    chk("mid_no_ack", ack_cnt - s_ack, 32'd0);
    bus.sram_dq_i = 16'hA55A;
    issue(1'b0, 18'h20001, 16'h0000, 2'b11);
    wait_ack(lat);
    chk("post_rd_lat",   lat, 32'd3);
    chk("post_rd_rdata", {16'd0, bus.ram_rdata}, 32'hA55A);
    wait_idle();

    // Write with no byte enables
    s_ack = ack_cnt; s_we = we_lo; s_ub = ub_lo; s_lb = lb_lo;
    issue(1'b1, 18'h00010, 16'hFFFF, 2'b00);
    wait_ack(lat);
    chk("w00_lat", lat, 32'd4);
    wait_idle();
    chk("w00_ack",   ack_cnt - s_ack, 32'd1);
    chk("w00_we_lo", we_lo - s_we,    32'd2);
`ifdef BLIT_SRAM_WSTRB_EN
    chk("w00_ub_lo", ub_lo - s_ub, 32'd0);
    chk("w00_lb_lo", lb_lo - s_lb, 32'd0);
`else
    chk("w00_ub_lo", ub_lo - s_ub, 32'd2);
    chk("w00_lb_lo", lb_lo - s_lb, 32'd2);
`endif

    // Whole-run pin invariants
    s_cf = conflict;
    chk("inv_conflict", s_cf,     32'd0);
    chk("inv_turn",     turn_bad, 32'd0);
    chk("inv_a_stable", a_bad,    32'd0);
    chk("inv_dq_stable", dq_bad,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
